// File: rtl/snake_vga_pkg.sv
// Shared types and screen constants for the snake game's VGA drawing path.
// Holds the rectangle descriptor and the scheduler state encoding.
package snake_vga_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    typedef logic [2:0] colour_t;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [7:0] w;
        logic [6:0] h;
        colour_t    colour;
    } rect_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        DONE = 2'd2
    } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: scans req from ptr upward (mod N) and returns
// a one-hot winner plus its index. The pointer itself lives in the parent.
module rr_arbiter #(
    parameter int N  = 3,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_idx,
    output logic          o_valid
);

    logic [IW-1:0] w_cand;

    // NOTE: every output gets a default before the scan so no path leaves a latch behind.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_cand  = '0;
        for (int k = 0; k < N; k++) begin
            w_cand = IW'((int'(i_ptr) + k) % N);
            if (!o_valid && i_req[w_cand]) begin
                o_valid         = 1'b1;
                o_idx           = w_cand;
                o_grant[w_cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vga_rect_scheduler.sv
// Shares the VGA adapter plot port between N rectangle requesters: round-robin grant,
// then one pixel per clock with clipping to the visible screen.
module vga_rect_scheduler #(
    parameter int N_REQ    = 3,
    parameter int SCREEN_W = snake_vga_pkg::SCREEN_W,
    parameter int SCREEN_H = snake_vga_pkg::SCREEN_H
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*8-1:0] rect_x,
    input  logic [N_REQ*7-1:0] rect_y,
    input  logic [N_REQ*8-1:0] rect_w,
    input  logic [N_REQ*7-1:0] rect_h,
    input  logic [N_REQ*3-1:0] rect_colour,
    output logic [N_REQ-1:0]   grant,
    output logic [N_REQ-1:0]   done,
    output logic               busy,
    output logic [7:0]         vga_x,
    output logic [6:0]         vga_y,
    output logic [2:0]         vga_colour,
    output logic               vga_plot
);

    import snake_vga_pkg::rect_t;
    import snake_vga_pkg::colour_t;
    import snake_vga_pkg::sched_state_t;
    import snake_vga_pkg::IDLE;
    import snake_vga_pkg::DRAW;
    import snake_vga_pkg::DONE;

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    sched_state_t     r_state, w_next;
    logic [IW-1:0]    r_ptr, r_idx, w_win_idx;
    logic [N_REQ-1:0] w_win_oh, r_grant, r_done;
    logic             w_win_valid;
    rect_t            r_rect, w_sel;
    logic [7:0]       r_cx, r_x;
    logic [6:0]       r_cy, r_y;
    colour_t          r_colour;
    logic             r_plot;
    logic [8:0]       w_px;
    logic [7:0]       w_py;
    logic             w_last_col, w_last_pix, w_sel_empty;

    rr_arbiter #(.N(N_REQ), .IW(IW)) u_arb (
        .i_req   (req),
        .i_ptr   (r_ptr),
        .o_grant (w_win_oh),
        .o_idx   (w_win_idx),
        .o_valid (w_win_valid)
    );

    always_comb begin
        w_sel.x      = rect_x[8*w_win_idx +: 8];
        w_sel.y      = rect_y[7*w_win_idx +: 7];
        w_sel.w      = rect_w[8*w_win_idx +: 8];
        w_sel.h      = rect_h[7*w_win_idx +: 7];
        w_sel.colour = rect_colour[3*w_win_idx +: 3];
        w_sel_empty  = (w_sel.w == 8'd0) || (w_sel.h == 7'd0);
        // Widened sums so off-screen coordinates clip instead of wrapping back on-screen.
        w_px         = {1'b0, r_rect.x} + {1'b0, r_cx};
        w_py         = {1'b0, r_rect.y} + {1'b0, r_cy};
        w_last_col   = (r_cx == r_rect.w - 8'd1);
        w_last_pix   = w_last_col && (r_cy == r_rect.h - 7'd1);
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_win_valid) w_next = w_sel_empty ? DONE : DRAW;
            DRAW:    if (w_last_pix) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // NOTE: the latched rectangle and raster counters are reset along with the outputs so a
    // reset mid-draw leaves nothing stale; these are a few flops, not a memory array.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr    <= '0;
            r_idx    <= '0;
            r_rect   <= '0;
            r_cx     <= '0;
            r_cy     <= '0;
            r_grant  <= '0;
            r_done   <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_colour <= '0;
            r_plot   <= 1'b0;
        end else begin
            r_done <= '0;
            r_plot <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    r_grant <= w_win_oh;
                    if (w_win_valid) begin
                        r_rect <= w_sel;
                        r_idx  <= w_win_idx;
                        r_cx   <= '0;
                        r_cy   <= '0;
                    end
                end
                DRAW: begin
                    r_x      <= w_px[7:0];
                    r_y      <= w_py[6:0];
                    r_colour <= r_rect.colour;
                    r_plot   <= (w_px < 9'(SCREEN_W)) && (w_py < 8'(SCREEN_H));
                    if (w_last_col) begin
                        r_cx <= '0;
                        r_cy <= r_cy + 7'd1;
                    end else begin
                        r_cx <= r_cx + 8'd1;
                    end
                end
                DONE: begin
                    r_done <= r_grant;
                    r_ptr  <= (r_idx == IW'(N_REQ - 1)) ? '0 : r_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign grant      = r_grant;
    assign done       = r_done;
    assign busy       = (r_state != IDLE);
    assign vga_x      = r_x;
    assign vga_y      = r_y;
    assign vga_colour = r_colour;
    assign vga_plot   = r_plot;

endmodule

// File: tb/tb_vga_rect_scheduler.sv
// Self-checking bench: a queue-based per-rectangle model predicts every cycle of
// grant/done/busy/pixel output, plus literal expectations for the directed scenarios.
module tb_vga_rect_scheduler;

    localparam int N = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req;
    logic [23:0] rect_x, rect_w;
    logic [20:0] rect_y, rect_h;
    logic [8:0]  rect_colour;
    logic [2:0]  grant, done;
    logic        busy;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_plot;

    always #5 clk = ~clk;

    vga_rect_scheduler #(.N_REQ(N), .SCREEN_W(160), .SCREEN_H(120)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .rect_x      (rect_x),
        .rect_y      (rect_y),
        .rect_w      (rect_w),
        .rect_h      (rect_h),
        .rect_colour (rect_colour),
        .grant       (grant),
        .done        (done),
        .busy        (busy),
        .vga_x       (vga_x),
        .vga_y       (vga_y),
        .vga_colour  (vga_colour),
        .vga_plot    (vga_plot)
    );

    typedef struct packed {
        logic [2:0] grant;
        logic [2:0] done;
        logic       busy;
        logic       plot;
        logic       chk;
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } exp_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t q[$];
    int   m_ptr = 0;

    int         cyc = 0;
    logic [7:0] px[$];
    logic [6:0] py[$];
    logic [2:0] pc[$];
    int         last_plot_cyc = 0;
    int         done_cyc = 0;
    int         done_cnt = 0;
    logic [2:0] gv[$];
    int         gl[$];
    logic [2:0] prev_grant = 3'b000;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One rectangle as the outside world sees it: grant cycle, w*h raster cycles, done cycle.
    task automatic push_rect();
        int         win = -1;
        int         x0, y0, w, h;
        logic [2:0] c, g;
        exp_t       r;
        for (int k = 0; k < N; k++) begin
            int j = (m_ptr + k) % N;
            if (win < 0 && req[j]) win = j;
        end
        m_ptr = (win + 1) % N;
        x0 = int'(rect_x[8*win +: 8]);
        y0 = int'(rect_y[7*win +: 7]);
        w  = int'(rect_w[8*win +: 8]);
        h  = int'(rect_h[7*win +: 7]);
        c  = rect_colour[3*win +: 3];
        g  = 3'(1 << win);
        r = '0; r.grant = g; r.busy = 1'b1;
        q.push_back(r);
        for (int yy = 0; yy < h; yy++) begin
            for (int xx = 0; xx < w; xx++) begin
                r = '0;
                r.grant = g;
                r.busy  = 1'b1;
                r.chk   = 1'b1;
                r.plot  = (x0 + xx < 160) && (y0 + yy < 120);
                r.x     = 8'(x0 + xx);
                r.y     = 7'(y0 + yy);
                r.c     = c;
                q.push_back(r);
            end
        end
        r = '0; r.grant = g; r.done = g;
        q.push_back(r);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (rst) begin
                q.delete();
                m_ptr = 0;
                e = '0;
                e.chk = 1'b1;
            end else begin
                if (q.size() == 0 && req != 3'b000) push_rect();
                if (q.size() != 0) e = q.pop_front();
                else               e = '0;
            end
            #1;
            cyc++;
            check($sformatf("grant@%0d", cyc), grant, e.grant);
            check($sformatf("done@%0d", cyc), done, e.done);
            check($sformatf("busy@%0d", cyc), busy, e.busy);
            check($sformatf("plot@%0d", cyc), vga_plot, e.plot);
            if (e.chk) begin
                check($sformatf("x@%0d", cyc), vga_x, e.x);
                check($sformatf("y@%0d", cyc), vga_y, e.y);
                check($sformatf("colour@%0d", cyc), vga_colour, e.c);
            end
            if (vga_plot) begin
                px.push_back(vga_x);
                py.push_back(vga_y);
                pc.push_back(vga_colour);
                last_plot_cyc = cyc;
            end
            if (done != 3'b000) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (grant != 3'b000) begin
                if (grant == prev_grant && gl.size() > 0) gl[gl.size()-1]++;
                else begin
                    gv.push_back(grant);
                    gl.push_back(1);
                end
            end
            prev_grant = grant;
        end
    end

    task automatic clear_logs();
        px.delete(); py.delete(); pc.delete();
        gv.delete(); gl.delete();
        done_cnt = 0;
    endtask

    task automatic set_rect(input int i, input int x, input int y, input int w, input int h,
                            input logic [2:0] c);
        rect_x[8*i +: 8]      = 8'(x);
        rect_y[7*i +: 7]      = 7'(y);
        rect_w[8*i +: 8]      = 8'(w);
        rect_h[7*i +: 7]      = 7'(h);
        rect_colour[3*i +: 3] = c;
    endtask

    task automatic wait_done(input int idx, input int budget, input string name);
        int n = 0;
        while (done[idx] !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(n < budget), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        rst = 1'b1; req = '0;
        rect_x = '0; rect_y = '0; rect_w = '0; rect_h = '0; rect_colour = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_grant", grant, 0);
        check("rst_plot", vga_plot, 0);
        rst = 1'b0;

        // Reset in the middle of a long rectangle
        set_rect(0, 5, 5, 20, 5, 3'b010);
        req = 3'b001;
        repeat (6) @(negedge clk);
        check("t1_busy_mid", busy, 1);
        clear_logs();
        rst = 1'b1; req = '0;
        repeat (2) @(negedge clk);
        check("t1_grant", grant, 0);
        check("t1_busy", busy, 0);
        check("t1_plot", vga_plot, 0);
        check("t1_x", vga_x, 0);
        check("t1_colour", vga_colour, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("t1_no_done", done_cnt, 0);
        check("t1_idle", busy, 0);

        // Three 1x1 requesters held together: order 0,1,2,0, three cycles each
        set_rect(0, 1, 1, 1, 1, 3'b001);
        set_rect(1, 2, 2, 1, 1, 3'b010);
        set_rect(2, 3, 3, 1, 1, 3'b011);
        clear_logs();
        req = 3'b111;
        n = 0;
        while (done_cnt < 4 && n < 40) begin
            @(negedge clk);
            n++;
        end
        req = 3'b000;
        check("t3_four_done", done_cnt, 4);
        repeat (2) @(negedge clk);
        check("t3_ngrants", gv.size(), 4);
        check("t3_g0", gv[0], 3'b001);
        check("t3_g1", gv[1], 3'b010);
        check("t3_g2", gv[2], 3'b100);
        check("t3_g3", gv[3], 3'b001);
        for (int k = 0; k < 4; k++) check($sformatf("t3_len%0d", k), gl[k], 3);

        // 3x2 rectangle at (10,20), colour 100
        clear_logs();
        set_rect(0, 10, 20, 3, 2, 3'b100);
        req = 3'b001;
        wait_done(0, 30, "t2_done_seen");
        req = 3'b000;
        repeat (2) @(negedge clk);
        check("t2_nplots", px.size(), 6);
        for (int k = 0; k < 6; k++) begin
            check($sformatf("t2_px%0d", k), px[k], 10 + k % 3);
            check($sformatf("t2_py%0d", k), py[k], 20 + k / 3);
            check($sformatf("t2_pc%0d", k), pc[k], 3'b100);
        end
        check("t2_done_gap", done_cyc - last_plot_cyc, 1);
        check("t2_done_cnt", done_cnt, 1);

        // Corner clipping: 4x2 at (158,119)
        clear_logs();
        set_rect(1, 158, 119, 4, 2, 3'b011);
        req = 3'b010;
        wait_done(1, 30, "t4_done_seen");
        req = 3'b000;
        repeat (2) @(negedge clk);
        check("t4_nplots", px.size(), 2);
        check("t4_x0", px[0], 158);
        check("t4_y0", py[0], 119);
        check("t4_x1", px[1], 159);
        check("t4_y1", py[1], 119);
        check("t4_grant_len", gl[0], 10);

        // Empty rectangle: grant, then done on the next cycle
        clear_logs();
        set_rect(2, 0, 0, 0, 5, 3'b111);
        req = 3'b100;
        wait_done(2, 10, "t5_done_seen");
        req = 3'b000;
        repeat (2) @(negedge clk);
        check("t5_nplots", px.size(), 0);
        check("t5_grant_len", gl[0], 2);
        check("t5_done_cnt", done_cnt, 1);

        // Drop req and move rect_x after two pixels; the latched rectangle is finished
        clear_logs();
        set_rect(0, 20, 30, 4, 4, 3'b001);
        req = 3'b001;
        n = 0;
        while (grant[0] !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("t6_granted", 32'(n < 10), 1);
        repeat (2) @(negedge clk);
        rect_x[7:0] = 8'd100;
        req = 3'b000;
        wait_done(0, 30, "t6_done_seen");
        repeat (2) @(negedge clk);
        check("t6_nplots", px.size(), 16);
        for (int k = 0; k < 16; k++) check($sformatf("t6_px%0d", k), px[k], 20 + k % 4);
        check("t6_done_cnt", done_cnt, 1);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
